queue_param_sync: RTL and testbench

Parametrised synchronous FIFO. It is the successor to the fixed 8x32 queue and generalises width and depth, including non-power-of-2 depths. Adds true simultaneous read/write, an occupancy count, programmable almost-full/almost-empty flags and a read-valid strobe. It sits between a producer and a consumer in one clock domain.

---
 rtl/queue_pkg.sv | 16 +
 rtl/queue_mem_dp.sv | 29 ++
 rtl/queue_param_sync.sv | 109 ++++++++++
 tb/tb_queue_param_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared constants and pointer helpers for the parametrised queue.
package queue_pkg;

  localparam int DEFAULT_WORD_LENGTH  = 8;
  localparam int DEFAULT_NUM_OF_WORDS = 32;

  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Explicit wrap so non-power-of-2 depths work.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/queue_mem_dp.sv
// Simple dual-port storage: one write port, one registered read port.
module queue_mem_dp #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Non-blocking read samples the old word on a same-address write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/queue_param_sync.sv
// Parametrised synchronous FIFO with count and threshold flags.
// Optional sticky overflow/underflow flags under QUEUE_ERR_FLAGS_EN.
module queue_param_sync
  import queue_pkg::*;
#(
  parameter int WORD_LENGTH        = DEFAULT_WORD_LENGTH,
  parameter int NUM_OF_WORDS       = DEFAULT_NUM_OF_WORDS,
  parameter int ALMOST_FULL_LEVEL  = NUM_OF_WORDS - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] data_in,
  input  logic                   write_to_stack,
  input  logic                   read_from_stack,
`ifdef QUEUE_ERR_FLAGS_EN
  input  logic                   err_clear,
  output logic                   overflow,
  output logic                   underflow,
`endif
  output logic [WORD_LENGTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   stack_full,
  output logic                   stack_empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ptr_width(NUM_OF_WORDS):0] word_count
);

  localparam int POINTER_WIDTH = ptr_width(NUM_OF_WORDS);
  localparam int CW = POINTER_WIDTH + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_OF_WORDS);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LEVEL);

  logic [POINTER_WIDTH-1:0] rd_ptr;
  logic [POINTER_WIDTH-1:0] wr_ptr;
  logic [POINTER_WIDTH-1:0] rd_ptr_nxt;
  logic [POINTER_WIDTH-1:0] wr_ptr_nxt;
  logic                     rd_acc;
  logic                     wr_acc;

  assign stack_full   = (word_count == FULL_CNT);
  assign stack_empty  = (word_count == '0);
  assign almost_full  = (word_count >= AF_CNT);
  assign almost_empty = (word_count <= AE_CNT);

  assign rd_acc = read_from_stack && !stack_empty;
  assign wr_acc = write_to_stack && (!stack_full || rd_acc);

  assign rd_ptr_nxt =
    POINTER_WIDTH'(next_ptr(int'(rd_ptr), NUM_OF_WORDS));
  assign wr_ptr_nxt =
    POINTER_WIDTH'(next_ptr(int'(wr_ptr), NUM_OF_WORDS));

  queue_mem_dp #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (NUM_OF_WORDS),
    .AW    (POINTER_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      word_count <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) rd_ptr <= rd_ptr_nxt;
      if (wr_acc) wr_ptr <= wr_ptr_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   word_count <= word_count + 1'b1;
        2'b01:   word_count <= word_count - 1'b1;
        default: word_count <= word_count;
      endcase
    end
  end

`ifdef QUEUE_ERR_FLAGS_EN
  logic ov_set;
  logic un_set;

  assign ov_set = write_to_stack && !wr_acc;
  // A read on empty alongside a write is not an underflow.
  assign un_set = read_from_stack && !rd_acc && !write_to_stack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ov_set || (overflow && !err_clear);
      underflow <= un_set || (underflow && !err_clear);
    end
  end
`endif

endmodule

// File: tb/tb_queue_param_sync.sv
// Scoreboard bench for queue_param_sync at depths 32 and 5.
module tb_queue_param_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       err_clr;

  logic [7:0] a_din, b_din;
  logic       a_wr, a_rd, b_wr, b_rd;
  logic [7:0] a_dout, b_dout;
  logic       a_dv, a_full, a_empty, a_af, a_ae;
  logic       b_dv, b_full, b_empty, b_af, b_ae;
  logic [5:0] a_cnt;
  logic [3:0] b_cnt;
`ifdef QUEUE_ERR_FLAGS_EN
  logic       a_ov, a_un, b_ov, b_un;
  bit         ov_a, un_a, ov_b, un_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq_a[$];
  logic [7:0] mq_b[$];
  logic [7:0] lo_a, lo_b;

  always #5 clk = ~clk;

  queue_param_sync #(.WORD_LENGTH(8), .NUM_OF_WORDS(32)) dut_a (
    .clk             (clk),
    .reset           (reset),
    .data_in         (a_din),
    .write_to_stack  (a_wr),
    .read_from_stack (a_rd),
`ifdef QUEUE_ERR_FLAGS_EN
    .err_clear       (err_clr),
    .overflow        (a_ov),
    .underflow       (a_un),
`endif
    .data_out        (a_dout),
    .data_valid      (a_dv),
    .stack_full      (a_full),
    .stack_empty     (a_empty),
    .almost_full     (a_af),
    .almost_empty    (a_ae),
    .word_count      (a_cnt)
  );

  queue_param_sync #(.WORD_LENGTH(8), .NUM_OF_WORDS(5)) dut_b (
    .clk             (clk),
    .reset           (reset),
    .data_in         (b_din),
    .write_to_stack  (b_wr),
    .read_from_stack (b_rd),
`ifdef QUEUE_ERR_FLAGS_EN
    .err_clear       (err_clr),
    .overflow        (b_ov),
    .underflow       (b_un),
`endif
    .data_out        (b_dout),
    .data_valid      (b_dv),
    .stack_full      (b_full),
    .stack_empty     (b_empty),
    .almost_full     (b_af),
    .almost_empty    (b_ae),
    .word_count      (b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int s, input int sz,
                            input logic [7:0] lo, input bit dv);
    int n;
    n = s ? 5 : 32;
    if (s == 0) begin
      check("a_count", 32'(a_cnt), sz);
      check("a_full", 32'(a_full), 32'(sz == n));
      check("a_empty", 32'(a_empty), 32'(sz == 0));
      check("a_afull", 32'(a_af), 32'(sz >= n - 2));
      check("a_aempty", 32'(a_ae), 32'(sz <= 2));
      check("a_valid", 32'(a_dv), 32'(dv));
      check("a_dout", 32'(a_dout), 32'(lo));
    end else begin
      check("b_count", 32'(b_cnt), sz);
      check("b_full", 32'(b_full), 32'(sz == n));
      check("b_empty", 32'(b_empty), 32'(sz == 0));
      check("b_afull", 32'(b_af), 32'(sz >= n - 2));
      check("b_aempty", 32'(b_ae), 32'(sz <= 2));
      check("b_valid", 32'(b_dv), 32'(dv));
      check("b_dout", 32'(b_dout), 32'(lo));
    end
  endtask

  task automatic cyc(input int s, input logic w, input logic r,
                     input logic [7:0] d);
    int n;
    bit ra, wa;
    logic [7:0] q[$];
    logic [7:0] lo;
`ifdef QUEUE_ERR_FLAGS_EN
    bit ov, un, ov_set, un_set;
`endif
    n = s ? 5 : 32;
    if (s == 0) begin
      q = mq_a; lo = lo_a;
      a_wr = w; a_rd = r; a_din = d;
    end else begin
      q = mq_b; lo = lo_b;
      b_wr = w; b_rd = r; b_din = d;
    end
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < n) || ra);
`ifdef QUEUE_ERR_FLAGS_EN
    ov = s ? ov_b : ov_a;
    un = s ? un_b : un_a;
    ov_set = w && !wa;
    un_set = r && !ra && !(w && q.size() == 0);
    ov = ov_set || (ov && !err_clr);
    un = un_set || (un && !err_clr);
`endif
    @(posedge clk);
    #1;
    a_wr = 1'b0; a_rd = 1'b0;
    b_wr = 1'b0; b_rd = 1'b0;
    if (ra) lo = q.pop_front();
    if (wa) q.push_back(d);
    check_outs(s, q.size(), lo, ra);
`ifdef QUEUE_ERR_FLAGS_EN
    if (s == 0) begin
      check("a_overflow", 32'(a_ov), 32'(ov));
      check("a_underflow", 32'(a_un), 32'(un));
      ov_a = ov; un_a = un;
    end else begin
      check("b_overflow", 32'(b_ov), 32'(ov));
      check("b_underflow", 32'(b_un), 32'(un));
      ov_b = ov; un_b = un;
    end
`endif
    if (s == 0) begin mq_a = q; lo_a = lo; end
    else        begin mq_b = q; lo_b = lo; end
  endtask

  task automatic clear_models();
    mq_a.delete(); mq_b.delete();
    lo_a = 8'h00; lo_b = 8'h00;
`ifdef QUEUE_ERR_FLAGS_EN
    ov_a = 0; un_a = 0; ov_b = 0; un_b = 0;
`endif
  endtask

  task automatic reset_mid();
    #3 reset = 1'b1;
    #1;
    clear_models();
    check_outs(0, 0, 8'h00, 1'b0);
    check_outs(1, 0, 8'h00, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; err_clr = 1'b0;
    a_wr = 0; a_rd = 0; a_din = 0;
    b_wr = 0; b_rd = 0; b_din = 0;
    clear_models();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_outs(0, 0, 8'h00, 1'b0);
    check_outs(1, 0, 8'h00, 1'b0);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'(8'h10 + i));
    check("a_count_pre_rst", 32'(a_cnt), 5);
    reset_mid();
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 32; i++) cyc(0, 1, 0, 8'(i));
    cyc(0, 1, 0, 8'hAA);
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 8'h00);

    for (int i = 0; i < 32; i++) cyc(0, 1, 0, 8'(8'h80 + i));
    cyc(0, 1, 1, 8'h55);
`ifdef QUEUE_ERR_FLAGS_EN
    cyc(0, 1, 0, 8'h77);
    cyc(0, 0, 0, 8'h00);
    err_clr = 1'b1;
    cyc(0, 1, 0, 8'h78);
    cyc(0, 0, 0, 8'h00);
    err_clr = 1'b0;
`endif
    for (int i = 0; i < 32; i++) cyc(0, 0, 1, 8'h00);

    cyc(0, 1, 1, 8'h3C);
    cyc(0, 0, 1, 8'h00);

    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    err_clr = 1'b1;
    cyc(0, 0, 0, 8'h00);
    err_clr = 1'b0;
    cyc(0, 0, 0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, i >= 2, 8'(8'hC0 + i));
      if (i % 4 == 3) begin
        cyc(1, 1, 0, 8'(8'hE0 + i));
        cyc(1, 0, 1, 8'h00);
      end
    end
    while (mq_b.size() > 0) cyc(1, 0, 1, 8'h00);
    cyc(1, 0, 1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
